ef_pwm_seq: RTL and testbench
=============================

EF_PWM_SEQ -- requirements
Module: ef_pwm_seq

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, giving the number of compare-table entries (power of 2, 2..64).
REQ-002 SHALL provide parameter AW, default 4, giving the table address width (log2 DEPTH).
REQ-003 SHALL provide port clk_i  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL provide ports tbl_we in 1, tbl_addr in AW, tbl_wdata in 32: compare-table write port.
REQ-006 SHALL provide ports start in 1 and stop in 1: single-cycle sequence start and abort strobes.
REQ-007 SHALL provide ports len in AW (index of last entry), loop in 1 (restart at entry 0 after last) and idle_cmp in 32 (compare value when not running).
REQ-008 SHALL provide port to_flag  in  1  timer time-out pulse, one cycle per period.
REQ-009 SHALL provide port pwm_cmp  out  32  compare value driven to the timer.
REQ-010 SHALL provide ports busy out 1, idx out AW (current entry) and done out 1 (single-cycle completion pulse).

Function
REQ-011 SHALL implement two states, IDLE and RUN.
REQ-012 SHALL, in IDLE with start=1 and stop=0, enter RUN, set idx=0 and load pwm_cmp=table[0] at the next edge.
REQ-013 SHALL, in RUN, treat a to_flag pulse as one step and apply its update at the following edge (1-cycle latency).
REQ-014 SHALL, on a step when idx<len, increment idx and load pwm_cmp=table[idx+1].
REQ-015 SHALL, on a step when idx==len and loop=1, set idx=0 and load pwm_cmp=table[0] without asserting done.
REQ-016 SHALL, on a step when idx==len and loop=0, return to IDLE, hold pwm_cmp at table[len] and assert done for exactly one cycle.
REQ-017 SHALL, on stop=1 in any state, enter IDLE, set idx=0 and load pwm_cmp=idle_cmp at the next edge, with no done pulse.
REQ-018 SHALL give stop priority over start and to_flag in the same cycle.
REQ-019 SHALL ignore start while in RUN.
REQ-020 SHALL accept table writes in any state; a write and a load of the same entry in the same cycle SHALL load the old data.
REQ-021 SHALL sample len and loop at each step; len=0 SHALL hold a single entry (looping or finishing on the first step).
REQ-022 SHALL drive busy=1 exactly while in RUN.
REQ-023 SHALL leave pwm_cmp unchanged in IDLE except on stop or start.

Reset
REQ-024 SHALL, on rst_i, set state=IDLE, idx=0, pwm_cmp=0, busy=0, done=0, repeat counter=0.
REQ-025 SHALL clear all table entries to 0 on rst_i.
REQ-026 SHALL abandon any in-progress sequence on rst_i, including mid-step.

Configuration
REQ-027 SHALL support macro EF_PWM_SEQ_REPEAT_EN.
REQ-028 SHALL, with the macro defined, add input rep (8 bits) and hold each entry for rep+1 steps: an 8-bit counter increments on each step, and idx advances when the counter equals rep; the counter clears on advance, start, stop and reset.
REQ-029 SHALL, without the macro, omit the rep port and counter and advance on every step.

Structure
REQ-030 SHALL place the state enum (IDLE, RUN) and the default DEPTH/AW constants in shared package ef_pwm_seq_pkg.
REQ-031 SHALL implement the table as sub-module ef_pwm_seq_tbl: DEPTH x 32, one synchronous write port, one combinational read port.

Verification
REQ-032 SHALL test: table {100,200,300}, len=2, loop=0, start, then three to_flag pulses -> pwm_cmp 100, 200, 300; done pulses once on the third step; busy drops; pwm_cmp stays 300.
REQ-033 SHALL test: same table, loop=1, seven to_flag pulses -> pwm_cmp sequence 100,200,300,100,200,300,100,200; done never asserted.
REQ-034 SHALL test: stop and to_flag in the same cycle during RUN with idle_cmp=5 -> pwm_cmp=5, idx=0, busy=0, done=0 next cycle.
REQ-035 SHALL test: write table[1]=777 in the same cycle that entry 1 is loaded -> old value loaded; on the next lap, 777 is loaded.
REQ-036 SHALL test: with EF_PWM_SEQ_REPEAT_EN and rep=2, table {10,20}, loop=0 -> pwm_cmp 10 for 3 steps, then 20 for 3 steps, then done.
REQ-037 SHALL test: rst_i asserted mid-RUN -> pwm_cmp=0, busy=0 and the table reads all zero immediately.

Source files
------------

// File: rtl/ef_pwm_seq_pkg.sv
// ef_pwm_seq_pkg -- shared types and default sizing for the PWM compare sequencer.
// Optional feature macro used across this slice: EF_PWM_SEQ_REPEAT_EN.
package ef_pwm_seq_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_AW    = 4;
  localparam int DATA_W        = 32;
  localparam int REP_W         = 8;

  // Sequencer is either parked (IDLE) or stepping through the table (RUN).
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ef_pwm_seq_if.sv
// ef_pwm_seq_if -- control, table-write and status signals of the PWM sequencer.
// master: the controlling side (CPU/bench); slave: the sequencer itself.
// With EF_PWM_SEQ_REPEAT_EN defined the per-entry repeat count 'rep' is added.
interface ef_pwm_seq_if
  import ef_pwm_seq_pkg::*;
#(
  parameter int AW = DEFAULT_AW
);

  // Compare-table write port
  logic              tbl_we;
  logic [AW-1:0]     tbl_addr;
  logic [DATA_W-1:0] tbl_wdata;

  // Sequence control
  logic              start;
  logic              stop;
  logic [AW-1:0]     len;
  logic              loop;
  logic [DATA_W-1:0] idle_cmp;
  logic              to_flag;
`ifdef EF_PWM_SEQ_REPEAT_EN
  logic [REP_W-1:0]  rep;
`endif

  // Status / timer-facing outputs
  logic [DATA_W-1:0] pwm_cmp;
  logic              busy;
  logic [AW-1:0]     idx;
  logic              done;

  modport master (
    output tbl_we, tbl_addr, tbl_wdata,
    output start, stop, len, loop, idle_cmp, to_flag,
`ifdef EF_PWM_SEQ_REPEAT_EN
    output rep,
`endif
    input  pwm_cmp, busy, idx, done
  );

  modport slave (
    input  tbl_we, tbl_addr, tbl_wdata,
    input  start, stop, len, loop, idle_cmp, to_flag,
`ifdef EF_PWM_SEQ_REPEAT_EN
    input  rep,
`endif
    output pwm_cmp, busy, idx, done
  );

endinterface

// File: rtl/ef_pwm_seq_tbl.sv
// ef_pwm_seq_tbl -- DEPTH x 32 compare table: one synchronous write port and one
// combinational read port. A write and a read of the same entry in one cycle
// returns the old contents, since the write only lands at the clock edge.
module ef_pwm_seq_tbl
  import ef_pwm_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Table storage: cleared on reset, written one entry per cycle.
  // NOTE: this memory is built from flops with an async clear because the whole
  // table must read zero the moment reset asserts; a RAM macro could not do that.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples
        // pre-edge values; blocking '=' here would create order-dependent races.
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ef_pwm_seq.sv
// ef_pwm_seq -- steps a PWM compare value through a table, one entry per timer
// time-out, optionally looping, with an abort that parks the output on idle_cmp.
// Optional macro EF_PWM_SEQ_REPEAT_EN: hold each entry for rep+1 time-outs.
module ef_pwm_seq
  import ef_pwm_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ef_pwm_seq_if.slave bus
);

  state_e            r_state, w_state_nxt;
  logic [AW-1:0]     r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_pwm_cmp, w_pwm_cmp_nxt;
  logic              r_done, w_done_nxt;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_advance;

`ifdef EF_PWM_SEQ_REPEAT_EN
  logic [REP_W-1:0]  r_rep_cnt, w_rep_cnt_nxt;

  // A step only moves to the next entry once the repeat counter reaches rep.
  assign w_advance = (r_rep_cnt == bus.rep);
`else
  assign w_advance = 1'b1;
`endif

  ef_pwm_seq_tbl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_tbl (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (bus.tbl_we),
    .i_waddr (bus.tbl_addr),
    .i_wdata (bus.tbl_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Next-state and next-output decode; stop outranks start and to_flag.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; a missing default would infer a latch.
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_pwm_cmp_nxt = r_pwm_cmp;
    w_done_nxt    = 1'b0;
    w_rd_addr     = '0;
`ifdef EF_PWM_SEQ_REPEAT_EN
    w_rep_cnt_nxt = r_rep_cnt;
`endif

    if (bus.stop) begin
      w_state_nxt   = IDLE;
      w_idx_nxt     = '0;
      w_pwm_cmp_nxt = bus.idle_cmp;
`ifdef EF_PWM_SEQ_REPEAT_EN
      w_rep_cnt_nxt = '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            w_state_nxt   = RUN;
            w_idx_nxt     = '0;
            w_rd_addr     = '0;
            w_pwm_cmp_nxt = w_rd_data;
`ifdef EF_PWM_SEQ_REPEAT_EN
            w_rep_cnt_nxt = '0;
`endif
          end
        end

        RUN: begin
          if (bus.to_flag) begin
`ifdef EF_PWM_SEQ_REPEAT_EN
            w_rep_cnt_nxt = w_advance ? '0 : r_rep_cnt + 1'b1;
`endif
            if (w_advance) begin
              // len and loop are sampled here, on every step. An idx already
              // past a freshly shortened len is treated as the last entry.
              if (r_idx < bus.len) begin
                w_rd_addr     = AW'(r_idx + 1'b1);
                w_idx_nxt     = w_rd_addr;
                w_pwm_cmp_nxt = w_rd_data;
              end else if (bus.loop) begin
                w_rd_addr     = '0;
                w_idx_nxt     = '0;
                w_pwm_cmp_nxt = w_rd_data;
              end else begin
                // Finish: pwm_cmp keeps the last entry, idx stays on it.
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
              end
            end
          end
        end

        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers; reset abandons any sequence in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_pwm_cmp <= '0;
      r_done    <= 1'b0;
`ifdef EF_PWM_SEQ_REPEAT_EN
      r_rep_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pwm_cmp <= w_pwm_cmp_nxt;
      r_done    <= w_done_nxt;
`ifdef EF_PWM_SEQ_REPEAT_EN
      r_rep_cnt <= w_rep_cnt_nxt;
`endif
    end
  end

  assign bus.pwm_cmp = r_pwm_cmp;
  assign bus.busy    = (r_state == RUN);
  assign bus.idx     = r_idx;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_ef_pwm_seq.sv
// tb_ef_pwm_seq -- directed self-checking bench for ef_pwm_seq.
// Inputs change 1 ns after a rising edge; outputs are checked at that point too.
// The repeat scenario is compiled in when EF_PWM_SEQ_REPEAT_EN is defined.
module tb_ef_pwm_seq;

  localparam int AW = 4;

  logic clk_i;
  logic rst_i;
  int   n_total;
  int   n_pass;

  ef_pwm_seq_if #(.AW(AW)) bus ();

  ef_pwm_seq #(
    .DEPTH (16),
    .AW    (AW)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tbl_write(input logic [AW-1:0] a, input logic [31:0] d);
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = a;
    bus.tbl_wdata = d;
    tick();
    bus.tbl_we    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic step();
    bus.to_flag = 1'b1;
    tick();
    bus.to_flag = 1'b0;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    #1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    logic [31:0] loop_exp [7];
    n_total = 0;
    n_pass  = 0;
    rst_i         = 1'b0;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_wdata = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.len       = '0;
    bus.loop      = 1'b0;
    bus.idle_cmp  = '0;
    bus.to_flag   = 1'b0;
`ifdef EF_PWM_SEQ_REPEAT_EN
    bus.rep       = '0;
`endif
    #2;
    apply_reset();
    check("rst_pwm",  bus.pwm_cmp, 0);
    check("rst_busy", bus.busy,    0);
    check("rst_idx",  bus.idx,     0);
    check("rst_done", bus.done,    0);

    // One-shot run over {100,200,300}
    tbl_write(0, 100);
    tbl_write(1, 200);
    tbl_write(2, 300);
    bus.len  = 2;
    bus.loop = 1'b0;
    pulse_start();
    check("os_start_pwm",  bus.pwm_cmp, 100);
    check("os_start_busy", bus.busy,    1);
    check("os_start_idx",  bus.idx,     0);
    step();
    check("os_s1_pwm",  bus.pwm_cmp, 200);
    check("os_s1_done", bus.done,    0);
    step();
    check("os_s2_pwm",  bus.pwm_cmp, 300);
    check("os_s2_idx",  bus.idx,     2);
    check("os_s2_done", bus.done,    0);
    step();
    check("os_s3_pwm",  bus.pwm_cmp, 300);
    check("os_s3_done", bus.done,    1);
    check("os_s3_busy", bus.busy,    0);
    tick();
    check("os_after_done", bus.done,    0);
    check("os_after_pwm",  bus.pwm_cmp, 300);
    step();  // time-out while idle must not move anything
    check("idle_flag_pwm",  bus.pwm_cmp, 300);
    check("idle_flag_busy", bus.busy,    0);

    // Looping run: seven steps
    loop_exp = '{200, 300, 100, 200, 300, 100, 200};
    bus.loop = 1'b1;
    pulse_start();
    check("lp_start_pwm", bus.pwm_cmp, 100);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("lp_s%0d_pwm", i + 1), bus.pwm_cmp, loop_exp[i]);
      check($sformatf("lp_s%0d_done", i + 1), bus.done, 0);
    end

    // start ignored while running
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("run_start_pwm", bus.pwm_cmp, 200);
    check("run_start_idx", bus.idx,     1);

    // stop beats to_flag and start in the same cycle
    bus.idle_cmp = 5;
    bus.stop     = 1'b1;
    bus.to_flag  = 1'b1;
    bus.start    = 1'b1;
    tick();
    bus.stop     = 1'b0;
    bus.to_flag  = 1'b0;
    bus.start    = 1'b0;
    check("stop_pwm",  bus.pwm_cmp, 5);
    check("stop_idx",  bus.idx,     0);
    check("stop_busy", bus.busy,    0);
    check("stop_done", bus.done,    0);

    // Write entry 1 in the same cycle it is loaded
    pulse_start();
    check("wr_start_pwm", bus.pwm_cmp, 100);
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = 1;
    bus.tbl_wdata = 777;
    step();
    bus.tbl_we    = 1'b0;
    check("wr_same_cycle_pwm", bus.pwm_cmp, 200);
    step();
    check("wr_lap_s2", bus.pwm_cmp, 300);
    step();
    check("wr_lap_s3", bus.pwm_cmp, 100);
    step();
    check("wr_next_lap_pwm", bus.pwm_cmp, 777);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // len=0, no loop: single entry, finishes on first step
    bus.len  = 0;
    bus.loop = 1'b0;
    pulse_start();
    check("l0_start_pwm", bus.pwm_cmp, 100);
    step();
    check("l0_done", bus.done,    1);
    check("l0_busy", bus.busy,    0);
    check("l0_pwm",  bus.pwm_cmp, 100);

    // Reset in the middle of a step while running
    bus.len  = 2;
    bus.loop = 1'b1;
    pulse_start();
    step();
    check("mr_pre_pwm", bus.pwm_cmp, 777);
    bus.to_flag = 1'b1;
    #2;
    rst_i = 1'b1;
    #1;
    check("mr_pwm_now",  bus.pwm_cmp, 0);
    check("mr_busy_now", bus.busy,    0);
    check("mr_idx_now",  bus.idx,     0);
    tick();
    rst_i       = 1'b0;
    bus.to_flag = 1'b0;
    check("mr_busy_held", bus.busy, 0);
    // Table must read zero: walk all three entries
    pulse_start();
    check("mr_tbl0", bus.pwm_cmp, 0);
    step();
    check("mr_tbl1", bus.pwm_cmp, 0);
    step();
    check("mr_tbl2", bus.pwm_cmp, 0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

`ifdef EF_PWM_SEQ_REPEAT_EN
    // Repeat: rep=2 holds each entry for three steps
    apply_reset();
    tbl_write(0, 10);
    tbl_write(1, 20);
    bus.len  = 1;
    bus.loop = 1'b0;
    bus.rep  = 2;
    pulse_start();
    check("rp_start", bus.pwm_cmp, 10);
    step(); check("rp_s1", bus.pwm_cmp, 10);
    step(); check("rp_s2", bus.pwm_cmp, 10);
    step(); check("rp_s3", bus.pwm_cmp, 20);
    step(); check("rp_s4", bus.pwm_cmp, 20);
    check("rp_s4_done", bus.done, 0);
    step(); check("rp_s5", bus.pwm_cmp, 20);
    check("rp_s5_done", bus.done, 0);
    step();
    check("rp_s6_done", bus.done,    1);
    check("rp_s6_busy", bus.busy,    0);
    check("rp_s6_pwm",  bus.pwm_cmp, 20);
    bus.rep = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
